// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one ripple-carry adder through a 2-stage pipeline.
// Optional subtract and signed-overflow support is enabled by defining ADDER_ARB_SUB_EN.
module adder_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  input  logic [NREQ-1:0]   sub_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      y,
  output logic              cout,
  output logic              ovf
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   win_s;
  logic [PW-1:0]   idx_s;
  logic            hit_s;
  logic            any_s;
  logic [NREQ-1:0] gnt_s;

  logic            s1_valid_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [NREQ-1:0] id_r;
`ifdef ADDER_ARB_SUB_EN
  logic            sub_r;
`else
  logic            unused_sub_s;
  assign unused_sub_s = ^sub_in;
`endif

  logic [N-1:0]    bop_s;
  logic [N-1:0]    sum_s;
  logic            c_s;
  logic            cout_s;
  logic            ovf_s;

  logic [N-1:0]    y_r;
  logic            cout_r;
  logic            ovf_r;
  logic [NREQ-1:0] done_r;

  // (base + k) mod NREQ for base < NREQ and 0 <= k <= NREQ
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= NREQ) ? PW'(s - NREQ) : PW'(s);
  endfunction

  // One-bit full adder cell: returns {carry_out, sum}
  function automatic logic [1:0] fulladder(input logic x, input logic z, input logic ci);
    return {(x & z) | (x & ci) | (z & ci), x ^ z ^ ci};
  endfunction

  // Round-robin search starting at ptr_r; first requesting index wins
  always_comb begin
    gnt_s = '0;
    win_s = '0;
    any_s = 1'b0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s        = wrap_inc(ptr_r, k);
      hit_s        = req[idx_s] & ~any_s;
      gnt_s[idx_s] = hit_s;
      win_s        = hit_s ? idx_s : win_s;
      any_s        = any_s | hit_s;
    end
  end

  // Stage 1: capture the winner's operands and advance the priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= '0;
      s1_valid_r <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= '0;
`ifdef ADDER_ARB_SUB_EN
      sub_r      <= 1'b0;
`endif
    end else begin
      s1_valid_r <= any_s;
      if (any_s) begin
        ptr_r <= wrap_inc(win_s, 1);
        a_r   <= a_in[win_s*N +: N];
        b_r   <= b_in[win_s*N +: N];
        id_r  <= gnt_s;
`ifdef ADDER_ARB_SUB_EN
        sub_r <= sub_in[win_s];
`endif
      end
    end
  end

  // Shared ripple-carry adder on the stage-1 registers; subtract inverts b with carry-in 1
  always_comb begin
`ifdef ADDER_ARB_SUB_EN
    bop_s = sub_r ? ~b_r : b_r;
    c_s   = sub_r;
`else
    bop_s = b_r;
    c_s   = 1'b0;
`endif
    sum_s = '0;
    for (int i = 0; i < N; i++) begin
      {c_s, sum_s[i]} = fulladder(a_r[i], bop_s[i], c_s);
    end
    cout_s = c_s;
`ifdef ADDER_ARB_SUB_EN
    ovf_s = sub_r ? ((a_r[N-1] != b_r[N-1]) & (sum_s[N-1] != a_r[N-1]))
                  : ((a_r[N-1] == b_r[N-1]) & (sum_s[N-1] != a_r[N-1]));
`else
    ovf_s = 1'b0;
`endif
  end

  // Stage 2: register the result every edge; done pulses only for valid stage-1 data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= '0;
    end else begin
      y_r    <= sum_s;
      cout_r <= cout_s;
      ovf_r  <= ovf_s;
      done_r <= id_r & {NREQ{s1_valid_r}};
    end
  end

  assign gnt  = gnt_s;
  assign done = done_r;
  assign y    = y_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, reset sequence,
// then randomized traffic against a scoreboard model.
module tb_adder_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 3;
`ifdef ADDER_ARB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic [NREQ-1:0]   sub_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      y;
  logic              cout;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .sub_in(sub_in),
    .gnt(gnt), .done(done), .y(y), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [NREQ-1:0] req;
    logic            sub;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [N-1:0]    y;
    logic            cout;
    logic            ovf;
  } vec_t;

  typedef struct {
    int              due;
    logic [NREQ-1:0] id;
    logic [N-1:0]    y;
    logic            cout;
    logic            ovf;
  } res_t;

  vec_t tbl[18];
  res_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // requester i gets a+i so every client presents a distinct operand
  task automatic drive(input logic [NREQ-1:0] r, input logic s, input logic [N-1:0] a,
                       input logic [N-1:0] b);
    req    = r;
    sub_in = {NREQ{s}};
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*N +: N] = a + N'(i);
      b_in[i*N +: N] = b;
    end
  endtask

  logic [N-1:0]    ra [NREQ];
  logic [N-1:0]    rb [NREQ];
  logic            rs [NREQ];
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] exp_g;
  logic [N:0]      full;
  logic [N-1:0]    ey;
  logic            ec;
  logic            eo;
  longint          sr;
  int              mptr;
  int              w;
  int              idx;
  int              cyc;
  res_t            er;

  initial begin
    logic [N-1:0] ysub;
    ysub = SUB_EN ? 32'hFFFF_FFFE : 32'd12;
    tbl[0]  = '{3'b001, 1'b0, 32'd4,          32'd4,      3'b001, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{3'b010, 1'b0, 32'h10,         32'h20,     3'b010, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b001, 32'd8,        1'b0, 1'b0};
    tbl[3]  = '{3'b100, 1'b0, 32'hFFFF_FFFD,  32'h1,      3'b100, 3'b010, 32'h31,       1'b0, 1'b0};
    tbl[4]  = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 32'h100,        32'h1000,   3'b001, 3'b100, 32'h0,        1'b1, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 32'h200,        32'h2000,   3'b010, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 32'h300,        32'h3000,   3'b100, 3'b001, 32'h1100,     1'b0, 1'b0};
    tbl[8]  = '{3'b111, 1'b0, 32'h400,        32'h4000,   3'b001, 3'b010, 32'h2201,     1'b0, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 32'h500,        32'h5000,   3'b010, 3'b100, 32'h3302,     1'b0, 1'b0};
    tbl[10] = '{3'b111, 1'b0, 32'h600,        32'h6000,   3'b100, 3'b001, 32'h4400,     1'b0, 1'b0};
    tbl[11] = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b010, 32'h5501,     1'b0, 1'b0};
    tbl[12] = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b100, 32'h6602,     1'b0, 1'b0};
    tbl[13] = '{3'b001, 1'b1, 32'd5,          32'd7,      3'b001, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[14] = '{3'b001, 1'b0, 32'h7FFF_FFFF,  32'h1,      3'b001, 3'b000, 32'h0,        1'b0, 1'b0};
    tbl[15] = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b001, ysub,         1'b0, 1'b0};
    tbl[16] = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b001, 32'h8000_0000, 1'b0, SUB_EN};
    tbl[17] = '{3'b000, 1'b0, 32'h0,          32'h0,      3'b000, 3'b000, 32'h0,        1'b0, 1'b0};

    // reset state: outputs cleared, gnt follows req with ptr = 0
    rst = 1'b1;
    drive(3'b111, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_gnt", gnt, 3'b001);
    check("rst_done", done, 3'b000);
    check("rst_y", y, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    drive(3'b000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].sub, tbl[i].a, tbl[i].b);
      #1;
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("tbl%0d_done", i), done, tbl[i].done);
      if (tbl[i].done != 3'b000) begin
        check($sformatf("tbl%0d_y", i), y, tbl[i].y);
        check($sformatf("tbl%0d_cout", i), cout, tbl[i].cout);
        check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      end
    end

    // reset with two operations in flight and ptr = 2
    @(negedge clk);
    drive(3'b011, 1'b0, 32'h40, 32'h1);
    #1 check("inflt_gnt0", gnt, 3'b010);
    @(negedge clk);
    drive(3'b010, 1'b0, 32'h80, 32'h1);
    #1 check("inflt_gnt1", gnt, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 1'b0, 32'h0, 32'h0);
    #1 check("inflt_done_rst", done, 3'b000);
    check("inflt_y_rst", y, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("inflt_done_rel", done, 3'b000);
    @(negedge clk);
    check("inflt_done_e", done, 3'b000);
    drive(3'b110, 1'b0, 32'h55, 32'h11);
    #1 check("post_rst_gnt", gnt, 3'b010);
    @(negedge clk);
    check("inflt_done_f", done, 3'b000);
    drive(3'b000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_rst_done", done, 3'b010);
    check("post_rst_y", y, 32'h67);

    // randomized traffic; requests are held until granted
    rst = 1'b1;
    drive(3'b000, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    cyc  = 0;
    pend = '0;
    sb.delete();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        er = sb.pop_front();
        check("rnd_done", done, er.id);
        check("rnd_y", y, er.y);
        check("rnd_cout", cout, er.cout);
        check("rnd_ovf", ovf, er.ovf);
      end else begin
        check("rnd_idle", done, 3'b000);
      end
      pend = pend | (NREQ'($urandom_range(0, 7)) & NREQ'($urandom_range(0, 7)));
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 5))
          0:       ra[i] = 32'hFFFF_FFFF;
          1:       ra[i] = 32'h7FFF_FFFF;
          2:       ra[i] = 32'h8000_0000;
          default: ra[i] = $urandom();
        endcase
        rb[i] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom();
        rs[i] = 1'($urandom_range(0, 1));
        a_in[i*N +: N] = ra[i];
        b_in[i*N +: N] = rb[i];
        sub_in[i]      = rs[i];
      end
      req = pend;
      #1;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (w < 0 && pend[idx]) w = idx;
      end
      exp_g = (w < 0) ? '0 : NREQ'(1 << w);
      check("rnd_gnt", gnt, exp_g);
      if (w >= 0) begin
        if (SUB_EN && rs[w]) begin
          ey = ra[w] - rb[w];
          ec = (ra[w] >= rb[w]);
          sr = longint'($signed(ra[w])) - longint'($signed(rb[w]));
        end else begin
          full = {1'b0, ra[w]} + {1'b0, rb[w]};
          ey   = full[N-1:0];
          ec   = full[N];
          sr   = longint'($signed(ra[w])) + longint'($signed(rb[w]));
        end
        eo = SUB_EN && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
        sb.push_back('{cyc + 2, exp_g, ey, ec, eo});
        mptr    = (w + 1) % NREQ;
        pend[w] = 1'b0;
      end
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
